// File: rtl/lcd_init_ctrl.sv
// HD44780 character-LCD sequencer: power-up wait, fixed 8-bit init list, then paced user byte writes.
// Define LCD_RESET_SEQ_EN to prepend the three 0x30 reset-by-instruction commands.
module lcd_init_ctrl #(
    parameter int unsigned POWERUP_CYCLES   = 2000000,
    parameter int unsigned FUNC_CYCLES      = 1950,
    parameter int unsigned CMD_CYCLES       = 1850,
    parameter int unsigned CLEAR_CYCLES     = 76500,
    parameter int unsigned DATA_CYCLES      = 2150,
    parameter int unsigned E_PULSE_CYCLES   = 25,
    parameter int unsigned RST_WAIT1_CYCLES = 205000,
    parameter int unsigned RST_WAIT2_CYCLES = 5000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       WR_VALID,
    input  logic       WR_RS,
    input  logic [7:0] WR_DATA,
    output logic       WR_READY,
    output logic       INIT_DONE,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB
);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_ISSUE,
        S_E_HIGH,
        S_WAIT,
        S_IDLE
    } state_t;

`ifdef LCD_RESET_SEQ_EN
    localparam logic [2:0] LAST_STEP = 3'd6;
`else
    localparam logic [2:0] LAST_STEP = 3'd3;
`endif

    // Every interval is counted down to a terminal count of 1, so zero would never expire.
    if (POWERUP_CYCLES == 0 || FUNC_CYCLES == 0 || CMD_CYCLES == 0 || CLEAR_CYCLES == 0 ||
        DATA_CYCLES == 0 || E_PULSE_CYCLES == 0 || RST_WAIT1_CYCLES == 0 ||
        RST_WAIT2_CYCLES == 0) begin : g_bad_cycles
        $error("lcd_init_ctrl: all cycle parameters must be at least 1");
    end

    function automatic logic [7:0] init_cmd(input logic [2:0] step);
`ifdef LCD_RESET_SEQ_EN
        case (step)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h38;
            3'd4:             return 8'h0C;
            3'd5:             return 8'h06;
            default:          return 8'h01;
        endcase
`else
        case (step)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h06;
            default: return 8'h01;
        endcase
`endif
    endfunction

    function automatic logic [31:0] init_wait(input logic [2:0] step);
`ifdef LCD_RESET_SEQ_EN
        case (step)
            3'd0:       return RST_WAIT1_CYCLES;
            3'd1:       return RST_WAIT2_CYCLES;
            3'd2:       return CMD_CYCLES;
            3'd3:       return FUNC_CYCLES;
            3'd4, 3'd5: return CMD_CYCLES;
            default:    return CLEAR_CYCLES;
        endcase
`else
        case (step)
            3'd0:       return FUNC_CYCLES;
            3'd1, 3'd2: return CMD_CYCLES;
            default:    return CLEAR_CYCLES;
        endcase
`endif
    endfunction

    // Clear (0x01) and Return Home (0x02/0x03) are the slow instructions.
    function automatic logic [31:0] user_wait(input logic rs, input logic [7:0] db);
        if (rs)
            return DATA_CYCLES;
        else if (db == 8'h01 || db == 8'h02 || db == 8'h03)
            return CLEAR_CYCLES;
        else
            return CMD_CYCLES;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  lcd_db_q, lcd_db_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_e_q, lcd_e_d;
    logic        init_done_q, init_done_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_POWERUP;
            cnt_q       <= POWERUP_CYCLES;
            step_q      <= 3'd0;
            lcd_db_q    <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            lcd_db_q    <= lcd_db_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_e_q     <= lcd_e_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        lcd_db_d    = lcd_db_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_e_d     = 1'b0;
        init_done_d = init_done_q;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == 32'd1) begin
                    state_d  = S_ISSUE;
                    step_d   = 3'd0;
                    lcd_db_d = init_cmd(3'd0);
                    lcd_rs_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_ISSUE: begin
                state_d = S_E_HIGH;
                cnt_d   = E_PULSE_CYCLES;
                lcd_e_d = 1'b1;
            end
            S_E_HIGH: begin
                if (cnt_q == 32'd1) begin
                    state_d = S_WAIT;
                    // The bus is still holding the command, so the user wait is decoded from it.
                    cnt_d   = init_done_q ? user_wait(lcd_rs_q, lcd_db_q) : init_wait(step_q);
                end else begin
                    cnt_d   = cnt_q - 32'd1;
                    lcd_e_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 32'd1) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (init_done_q) begin
                    state_d = S_IDLE;
                end else if (step_q == LAST_STEP) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    state_d  = S_ISSUE;
                    step_d   = step_q + 3'd1;
                    lcd_db_d = init_cmd(step_q + 3'd1);
                    lcd_rs_d = 1'b0;
                end
            end
            S_IDLE: begin
                if (WR_VALID && init_done_q) begin
                    state_d  = S_ISSUE;
                    lcd_db_d = WR_DATA;
                    lcd_rs_d = WR_RS;
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = POWERUP_CYCLES;
                step_d  = 3'd0;
            end
        endcase
    end

    assign WR_READY  = (state_q == S_IDLE) && init_done_q;
    assign INIT_DONE = init_done_q;
    assign LCD_RS    = lcd_rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_E     = lcd_e_q;
    assign LCD_DB    = lcd_db_q;

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// Self-checking bench for lcd_init_ctrl: init sequence timing, user writes, back-to-back requests, reset abort.
module tb_lcd_init_ctrl;

    localparam int unsigned P  = 100;
    localparam int unsigned F  = 12;
    localparam int unsigned C  = 10;
    localparam int unsigned CL = 40;
    localparam int unsigned D  = 14;
    localparam int unsigned EP = 3;
    localparam int unsigned R1 = 30;
    localparam int unsigned R2 = 20;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       WR_VALID = 1'b0;
    logic       WR_RS = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       WR_READY, INIT_DONE, LCD_RS, LCD_RW, LCD_E;
    logic [7:0] LCD_DB;

    lcd_init_ctrl #(
        .POWERUP_CYCLES(P), .FUNC_CYCLES(F), .CMD_CYCLES(C), .CLEAR_CYCLES(CL),
        .DATA_CYCLES(D), .E_PULSE_CYCLES(EP), .RST_WAIT1_CYCLES(R1), .RST_WAIT2_CYCLES(R2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .WR_VALID(WR_VALID), .WR_RS(WR_RS), .WR_DATA(WR_DATA),
        .WR_READY(WR_READY), .INIT_DONE(INIT_DONE), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_E(LCD_E), .LCD_DB(LCD_DB)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse/edge history observed on the panel side.
    int unsigned rise_q[$], fall_q[$], rdy_q[$], done_q[$];
    logic [7:0]  rdb_q[$], fdb_q[$];
    logic        rrs_q[$];
    logic        prev_e = 1'b0, prev_r = 1'b0, prev_d = 1'b0;

    always @(negedge CLK) begin
        if (LCD_E && !prev_e) begin
            rise_q.push_back(cyc); rdb_q.push_back(LCD_DB); rrs_q.push_back(LCD_RS);
        end
        if (!LCD_E && prev_e) begin
            fall_q.push_back(cyc); fdb_q.push_back(LCD_DB);
        end
        if (WR_READY && !prev_r) rdy_q.push_back(cyc);
        if (INIT_DONE && !prev_d) done_q.push_back(cyc);
        prev_e <= LCD_E;
        prev_r <= WR_READY;
        prev_d <= INIT_DONE;
    end

    // Reference: the init command list and its waits.
    logic [7:0]  init_db[$];
    int unsigned init_w[$];
    int unsigned rel;

    function automatic int unsigned user_wait(input logic rs, input logic [7:0] d);
        if (rs) return D;
        if (d inside {8'h01, 8'h02, 8'h03}) return CL;
        return C;
    endfunction

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic pick(output logic rs, output logic [7:0] d);
        rs = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
        else d = 8'($urandom_range(0, 255));
    endtask

    // Hold reset then release; rel is the last edge that still sampled RESET high.
    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        rel = cyc;
    endtask

    // Wait for the first LCD_E high after release; check its timing and the command on the bus.
    task automatic check_first_rise(input string nm);
        int unsigned t = 0;
        while (!LCD_E && t < P + 50) begin tick(); t++; end
        checks++;
        if (cyc !== rel + P + 1) begin
            errors++; $display("FAIL %s_first_rise: edge %0d, expected %0d", nm, cyc - rel, P + 1);
        end
        checks++;
        if (LCD_DB !== init_db[0] || LCD_RS !== 1'b0) begin
            errors++; $display("FAIL %s_first_cmd: db=%h rs=%b, expected db=%h rs=0", nm, LCD_DB, LCD_RS, init_db[0]);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) tick();
        checks++;
        if ({LCD_E, LCD_RS, LCD_RW, WR_READY, INIT_DONE, LCD_DB} !== 13'b0) begin
            errors++;
            $display("FAIL reset_outputs: e=%b rs=%b rw=%b rdy=%b done=%b db=%h, expected all 0",
                     LCD_E, LCD_RS, LCD_RW, WR_READY, INIT_DONE, LCD_DB);
        end
        RESET = 1'b0;
        rel = cyc;
    endtask

    task automatic test_init_sequence();
        int unsigned rb = rise_q.size(), fb = fall_q.size(), n = init_db.size(), t = 0;
        while (!INIT_DONE && t < 5000) begin tick(); t++; end
        tick();
        checks++;
        if (!INIT_DONE) begin
            errors++; $display("FAIL init_timeout: INIT_DONE=%b after %0d cycles, expected 1", INIT_DONE, t);
            return;
        end
        checks++;
        if (rise_q.size() - rb != n || fall_q.size() - fb != n) begin
            errors++; $display("FAIL init_pulse_count: %0d rises %0d falls, expected %0d", rise_q.size() - rb, fall_q.size() - fb, n);
            return;
        end
        checks++;
        if (rise_q[rb] !== rel + P + 1) begin
            errors++; $display("FAIL init_first_rise: edge %0d, expected %0d", rise_q[rb] - rel, P + 1);
        end
        for (int i = 0; i < int'(n); i++) begin
            checks++;
            if (rdb_q[rb+i] !== init_db[i] || rrs_q[rb+i] !== 1'b0 || fdb_q[fb+i] !== init_db[i]) begin
                errors++; $display("FAIL init_cmd[%0d]: db=%h rs=%b fall_db=%h, expected db=%h rs=0",
                                   i, rdb_q[rb+i], rrs_q[rb+i], fdb_q[fb+i], init_db[i]);
            end
            checks++;
            if (fall_q[fb+i] - rise_q[rb+i] !== EP) begin
                errors++; $display("FAIL init_e_width[%0d]: %0d, expected %0d", i, fall_q[fb+i] - rise_q[rb+i], EP);
            end
            if (i + 1 < int'(n)) begin
                checks++;
                if (rise_q[rb+i+1] - fall_q[fb+i] !== init_w[i] + 1) begin
                    errors++; $display("FAIL init_gap[%0d]: %0d, expected %0d", i, rise_q[rb+i+1] - fall_q[fb+i], init_w[i] + 1);
                end
            end
        end
        checks++;
        if (done_q[done_q.size()-1] - fall_q[fb+n-1] !== init_w[n-1]) begin
            errors++; $display("FAIL init_clear_wait: %0d, expected %0d", done_q[done_q.size()-1] - fall_q[fb+n-1], init_w[n-1]);
        end
        checks++;
        if (rdy_q.size() == 0 || rdy_q[rdy_q.size()-1] !== done_q[done_q.size()-1]) begin
            errors++; $display("FAIL init_ready_with_done: ready rises=%0d, expected one on edge %0d", rdy_q.size(), done_q[done_q.size()-1]);
        end
    endtask

    task automatic single_write(input logic rs, input logic [7:0] d);
        int unsigned t = 0, rb, fb, yb, k;
        while (!WR_READY && t < 500) begin tick(); t++; end
        rb = rise_q.size(); fb = fall_q.size(); yb = rdy_q.size();
        WR_VALID = 1'b1; WR_RS = rs; WR_DATA = d;
        k = cyc + 1;
        tick();
        WR_VALID = 1'b0;
        WR_DATA = ~d;
        checks++;
        if (WR_READY !== 1'b0) begin
            errors++; $display("FAIL wr_ready_drop: %b after accept, expected 0", WR_READY);
        end
        t = 0;
        while (!WR_READY && t < 500) begin tick(); t++; end
        tick();
        checks++;
        if (rise_q.size() - rb != 1 || fall_q.size() - fb != 1 || rdy_q.size() - yb != 1) begin
            errors++; $display("FAIL wr_pulse_count: rises=%0d readys=%0d, expected 1 and 1", rise_q.size() - rb, rdy_q.size() - yb);
            return;
        end
        checks++;
        if (rise_q[rb] !== k + 1 || fall_q[fb] - rise_q[rb] !== EP) begin
            errors++; $display("FAIL wr_e_timing: rise %0d width %0d, expected rise %0d width %0d",
                               rise_q[rb], fall_q[fb] - rise_q[rb], k + 1, EP);
        end
        checks++;
        if (rdb_q[rb] !== d || rrs_q[rb] !== rs || fdb_q[fb] !== d) begin
            errors++; $display("FAIL wr_bus: db=%h rs=%b, expected db=%h rs=%b", rdb_q[rb], rrs_q[rb], d, rs);
        end
        checks++;
        if (rdy_q[yb] - k !== 1 + EP + user_wait(rs, d)) begin
            errors++; $display("FAIL wr_busy(rs=%b db=%h): %0d, expected %0d", rs, d, rdy_q[yb] - k, 1 + EP + user_wait(rs, d));
        end
    endtask

    task automatic test_user_writes();
        logic       rs;
        logic [7:0] d;
        single_write(1'b1, 8'h41);
        single_write(1'b0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            pick(rs, d);
            single_write(rs, d);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        int unsigned acc[$];
        logic [7:0]  exd[$];
        logic        exr[$];
        logic        rs;
        logic [7:0]  d;
        int unsigned rb = rise_q.size(), t = 0;
        pick(rs, d);
        WR_VALID = 1'b1; WR_RS = rs; WR_DATA = d;
        while (acc.size() < N && t < 3000) begin
            if (WR_READY) begin
                acc.push_back(cyc + 1); exd.push_back(WR_DATA); exr.push_back(WR_RS);
            end
            tick(); t++;
            if (!WR_READY) begin
                pick(rs, d);
                WR_RS = rs; WR_DATA = d;
            end
        end
        WR_VALID = 1'b0;
        t = 0;
        while (!WR_READY && t < 500) begin tick(); t++; end
        tick();
        checks++;
        if (acc.size() != N || rise_q.size() - rb != N) begin
            errors++; $display("FAIL b2b_count: accepts=%0d pulses=%0d, expected %0d", acc.size(), rise_q.size() - rb, N);
            return;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rise_q[rb+i] !== acc[i] + 1 || rdb_q[rb+i] !== exd[i] || rrs_q[rb+i] !== exr[i]) begin
                errors++; $display("FAIL b2b_pulse[%0d]: rise=%0d db=%h rs=%b, expected rise=%0d db=%h rs=%b",
                                   i, rise_q[rb+i], rdb_q[rb+i], rrs_q[rb+i], acc[i] + 1, exd[i], exr[i]);
            end
            if (i + 1 < N) begin
                checks++;
                if (acc[i+1] - acc[i] !== 2 + EP + user_wait(exr[i], exd[i])) begin
                    errors++; $display("FAIL b2b_spacing[%0d]: %0d, expected %0d", i, acc[i+1] - acc[i], 2 + EP + user_wait(exr[i], exd[i]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int unsigned t = 0;
        apply_reset();
        while (!(LCD_E && LCD_DB == 8'h0C) && t < 2000) begin tick(); t++; end
        checks++;
        if (!(LCD_E && LCD_DB == 8'h0C)) begin
            errors++; $display("FAIL midpulse_reach: e=%b db=%h, expected e=1 db=0c", LCD_E, LCD_DB);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (LCD_E !== 1'b0 || INIT_DONE !== 1'b0 || LCD_DB !== 8'h00) begin
            errors++; $display("FAIL midpulse_abort: e=%b done=%b db=%h, expected 0 0 00", LCD_E, INIT_DONE, LCD_DB);
        end
        RESET = 1'b0;
        rel = cyc;
        check_first_rise("midpulse");
    endtask

    task automatic test_reset_mid_write();
        int unsigned t = 0;
        while (!INIT_DONE && t < 5000) begin tick(); t++; end
        WR_VALID = 1'b1; WR_RS = 1'b1; WR_DATA = 8'h5A;
        t = 0;
        while (!LCD_E && t < 500) begin tick(); t++; end
        WR_VALID = 1'b0;
        checks++;
        if (LCD_E !== 1'b1 || INIT_DONE !== 1'b1) begin
            errors++; $display("FAIL midwrite_reach: e=%b done=%b, expected 1 1", LCD_E, INIT_DONE);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (LCD_E !== 1'b0 || INIT_DONE !== 1'b0 || WR_READY !== 1'b0) begin
            errors++; $display("FAIL midwrite_abort: e=%b done=%b rdy=%b, expected 0 0 0", LCD_E, INIT_DONE, WR_READY);
        end
        RESET = 1'b0;
        rel = cyc;
        check_first_rise("midwrite");
    endtask

    initial begin
`ifdef LCD_RESET_SEQ_EN
        init_db.push_back(8'h30); init_w.push_back(R1);
        init_db.push_back(8'h30); init_w.push_back(R2);
        init_db.push_back(8'h30); init_w.push_back(C);
`endif
        init_db.push_back(8'h38); init_w.push_back(F);
        init_db.push_back(8'h0C); init_w.push_back(C);
        init_db.push_back(8'h06); init_w.push_back(C);
        init_db.push_back(8'h01); init_w.push_back(CL);

        test_reset();
        test_init_sequence();
        test_user_writes();
        test_back_to_back();
        test_reset_mid_pulse();
        test_reset_mid_write();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_init_ctrl.md
# lcd_init_ctrl

HD44780-compatible character-LCD controller sitting directly downstream of the phase-timing counter. It runs the power-up wait and the fixed 8-bit initialisation command sequence, pacing each step with the timing phases it consumes (40 ms, 39 µs, 37 µs, 37 µs, 1.53 ms at 50 MHz). It then accepts byte writes from the display-content logic over a valid/ready handshake, and generates LCD_E pulses and execution waits so the panel is never overrun.

## Interface
- POWERUP_CYCLES, 2000000: wait after reset before the first command (40 ms).
- FUNC_CYCLES, 1950: execution wait after Function Set (39 µs).
- CMD_CYCLES, 1850: execution wait after Display On, Entry Mode, and user instruction writes (37 µs).
- CLEAR_CYCLES, 76500: execution wait after Clear/Home (1.53 ms).
- DATA_CYCLES, 2150: execution wait after a data write with RS=1 (43 µs).
- E_PULSE_CYCLES, 25: LCD_E high time (500 ns).
- RST_WAIT1_CYCLES, 205000 / RST_WAIT2_CYCLES, 5000: waits used only with LCD_RESET_SEQ_EN.
- CLK  in  1  system clock, 50 MHz; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- WR_VALID  in  1  user write request.
- WR_RS  in  1  0 = instruction, 1 = data.
- WR_DATA  in  8  byte to write.
- WR_READY  out  1  block can accept a write.
- INIT_DONE  out  1  initialisation complete; stays high until reset.
- LCD_RS  out  1  panel register select.
- LCD_RW  out  1  constant 0 (write only).
- LCD_E  out  1  panel enable strobe.
- LCD_DB  out  8  panel data bus.

## Operation
- States: POWERUP, ISSUE, E_HIGH, WAIT, IDLE. An init-step index (0..3) selects the command and its wait.
- Reset values: all outputs 0. State = POWERUP. Wait counter = POWERUP_CYCLES. Step = 0.
- POWERUP: counts down to 0, then goes to ISSUE with step 0.
- Init command list:
  - 0x38 Function Set, wait FUNC_CYCLES
  - 0x0C Display On, wait CMD_CYCLES
  - 0x06 Entry Mode, wait CMD_CYCLES
  - 0x01 Clear, wait CLEAR_CYCLES
- All init commands use LCD_RS=0.
- ISSUE (1 cycle): LCD_RS/LCD_DB are already registered, with LCD_E=0. Next state is E_HIGH.
- E_HIGH: LCD_E=1 for exactly E_PULSE_CYCLES cycles, then WAIT.
- WAIT: LCD_E=0 and LCD_DB/LCD_RS held. Counts the selected wait down to 0.
  - During init, it then advances the step, or after step 3 sets INIT_DONE and goes to IDLE.
  - In user mode, it returns to IDLE.
- IDLE: WR_READY = INIT_DONE. A write is accepted on an edge where WR_VALID && WR_READY; WR_DATA/WR_RS are loaded into LCD_DB/LCD_RS on that edge and the state becomes ISSUE.
- User wait selection:
  - WR_RS=1: DATA_CYCLES.
  - WR_RS=0 and WR_DATA ∈ {0x01,0x02,0x03}: CLEAR_CYCLES.
  - Otherwise: CMD_CYCLES.
- Counter: a single 32-bit unsigned down-counter. All cycle parameters must be ≥1 and <2^32. Zero is not supported.
- WR_VALID while not ready is ignored; no queueing. The requester must hold the request until it is accepted.
- RESET at any time, including mid-pulse, aborts immediately: LCD_E=0 the next cycle and the full power-up sequence restarts.

## Timing
- First LCD_E rise: POWERUP_CYCLES+1 cycles after RESET deasserts.
- Per command, LCD_DB is stable 1 cycle before LCD_E rises and for the whole wait after it falls.
- Write accepted at edge k:
  - WR_READY low after edge k.
  - LCD_E high during cycles k+1 .. k+E_PULSE_CYCLES.
  - WR_READY high again after edge k+1+E_PULSE_CYCLES+wait.
- INIT_DONE and WR_READY rise on the same edge, when the Clear wait expires.

## Configuration
- LCD_RESET_SEQ_EN defined:
  - Before the init list, issue 0x30 three times, with waits RST_WAIT1_CYCLES, RST_WAIT2_CYCLES and CMD_CYCLES (reset-by-instruction).
  - The step index then extends to 0..6.
- LCD_RESET_SEQ_EN undefined: only the four-command list runs; the RST_WAIT parameters are unused.

## Test plan
- Sim params POWERUP=100, FUNC=12, CMD=10, CLEAR=40, DATA=14, E_PULSE=3; release RESET -> LCD_E first rises 101 cycles later with DB=0x38, RS=0, and is high exactly 3 cycles.
- Same run -> observed DB sequence 0x38, 0x0C, 0x06, 0x01, with post-fall gaps of 12, 10, 10, 40 cycles. INIT_DONE=1 and WR_READY=1 on the same edge.
- After init, write RS=1, DATA=0x41 -> one E pulse with DB=0x41, RS=1; WR_READY low for 1+3+14=18 cycles.
- Write RS=0, DATA=0x01 -> busy 44 cycles. WR_VALID held throughout with new data -> exactly one pulse per accept, none while WR_READY=0.
- Assert RESET during the E_HIGH of the Display On command -> LCD_E=0, INIT_DONE=0 next cycle. The full 100-cycle power-up and 0x38 are repeated.
- With LCD_RESET_SEQ_EN defined, RST_WAIT1=30, RST_WAIT2=20 -> DB sequence 0x30, 0x30, 0x30, 0x38, 0x0C, 0x06, 0x01, with the first gaps 30, 20, 10.
